// File: rtl/rs_alloc_ctrl.sv
// Reservation-station entry allocator: grants up to two free entries per cycle,
// tracks occupancy, releases entries on issue and clears everything on flush.
module rs_alloc_ctrl #(
  parameter int RS_ENT_NUM = 8,
  parameter int RS_ENT_SEL = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rs_req_1,
  input  logic                  i_rs_req_2,
  input  logic [1:0]            i_rs_req_num,
  input  logic                  i_dp_stall_ext,
  input  logic                  i_flush,
  input  logic                  i_issue_vld,
  input  logic [RS_ENT_SEL-1:0] i_issue_ent,
  output logic                  o_rs_stall,
  output logic                  o_alloc_vld_1,
  output logic [RS_ENT_SEL-1:0] o_alloc_ent_1,
  output logic                  o_alloc_vld_2,
  output logic [RS_ENT_SEL-1:0] o_alloc_ent_2,
  output logic [RS_ENT_NUM-1:0] o_busy_vec,
  output logic [RS_ENT_SEL:0]   o_free_cnt
);

  logic [RS_ENT_NUM-1:0] r_busy_vec, w_busy_nxt;
  logic [RS_ENT_SEL:0]   r_free_cnt, w_free_nxt;
  logic [RS_ENT_SEL-1:0] w_e0, w_e1;
  logic                  w_f0, w_f1;
  logic                  w_commit, w_rel;

  // Priority search over the registered bitmap: first and second free entries.
  always_comb begin
    w_e0 = '0;
    w_e1 = '0;
    w_f0 = 1'b0;
    w_f1 = 1'b0;
    for (int i = 0; i < RS_ENT_NUM; i++) begin
      if (!r_busy_vec[i]) begin
        if (!w_f0) begin
          w_e0 = RS_ENT_SEL'(i);
          w_f0 = 1'b1;
        end else if (!w_f1) begin
          w_e1 = RS_ENT_SEL'(i);
          w_f1 = 1'b1;
        end
      end
    end
  end

  assign o_rs_stall    = (RS_ENT_SEL+1)'(i_rs_req_num) > r_free_cnt;
  assign w_commit      = !o_rs_stall && !i_dp_stall_ext && !i_flush;
  assign o_alloc_vld_1 = i_rs_req_1 && w_commit;
  assign o_alloc_vld_2 = i_rs_req_2 && w_commit;
  assign o_alloc_ent_1 = i_rs_req_1 ? w_e0 : '0;
  assign o_alloc_ent_2 = (i_rs_req_1 && i_rs_req_2) ? w_e1 :
                         i_rs_req_2                 ? w_e0 : '0;

  // Released entry is still busy during selection, so it never collides with a grant.
  assign w_rel = i_issue_vld && r_busy_vec[i_issue_ent];

  always_comb begin
    w_busy_nxt = r_busy_vec;
    if (w_rel)         w_busy_nxt[i_issue_ent]   = 1'b0;
    if (o_alloc_vld_1) w_busy_nxt[o_alloc_ent_1] = 1'b1;
    if (o_alloc_vld_2) w_busy_nxt[o_alloc_ent_2] = 1'b1;
    w_free_nxt = r_free_cnt + (RS_ENT_SEL+1)'(w_rel)
               - (RS_ENT_SEL+1)'(o_alloc_vld_1) - (RS_ENT_SEL+1)'(o_alloc_vld_2);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_busy_vec <= '0;
      r_free_cnt <= (RS_ENT_SEL+1)'(RS_ENT_NUM);
    end else begin
      r_busy_vec <= w_busy_nxt;
      r_free_cnt <= w_free_nxt;
    end
  end

  assign o_busy_vec = r_busy_vec;
  assign o_free_cnt = r_free_cnt;

  a_req_num: assert property (@(posedge i_clk) disable iff (i_rst)
    i_rs_req_num == ({1'b0, i_rs_req_1} + {1'b0, i_rs_req_2}));
  a_free_rng: assert property (@(posedge i_clk) disable iff (i_rst)
    r_free_cnt <= (RS_ENT_SEL+1)'(RS_ENT_NUM));

endmodule

// File: tb/tb_rs_alloc_ctrl.sv
// Scoreboard bench for rs_alloc_ctrl: a behavioural model queues expected grants,
// which are popped and compared mid-cycle; state is compared after each edge.
module tb_rs_alloc_ctrl;

  logic       i_clk, i_rst;
  logic       i_rs_req_1, i_rs_req_2;
  logic [1:0] i_rs_req_num;
  logic       i_dp_stall_ext, i_flush, i_issue_vld;
  logic [2:0] i_issue_ent;
  logic       o_rs_stall, o_alloc_vld_1, o_alloc_vld_2;
  logic [2:0] o_alloc_ent_1, o_alloc_ent_2;
  logic [7:0] o_busy_vec;
  logic [3:0] o_free_cnt;

  rs_alloc_ctrl #(.RS_ENT_NUM(8), .RS_ENT_SEL(3)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_rs_req_1(i_rs_req_1), .i_rs_req_2(i_rs_req_2), .i_rs_req_num(i_rs_req_num),
    .i_dp_stall_ext(i_dp_stall_ext), .i_flush(i_flush),
    .i_issue_vld(i_issue_vld), .i_issue_ent(i_issue_ent),
    .o_rs_stall(o_rs_stall),
    .o_alloc_vld_1(o_alloc_vld_1), .o_alloc_ent_1(o_alloc_ent_1),
    .o_alloc_vld_2(o_alloc_vld_2), .o_alloc_ent_2(o_alloc_ent_2),
    .o_busy_vec(o_busy_vec), .o_free_cnt(o_free_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       stall;
    logic       v1;
    logic [2:0] e1;
    logic       v2;
    logic [2:0] e2;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  logic [7:0] m_busy;
  int         m_free;

  logic       s_stall, s_v1, s_v2;
  logic [2:0] s_e1, s_e2;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, queue expectation, compare outputs at negedge, state after edge.
  task automatic cyc(input logic rst, input logic r1, input logic r2, input logic ext,
                     input logic fl, input logic iv, input logic [2:0] ie);
    exp_t e;
    int   fr[$];
    int   nreq;
    logic commit;
    i_rst = rst; i_rs_req_1 = r1; i_rs_req_2 = r2;
    i_rs_req_num = {1'b0, r1} + {1'b0, r2};
    i_dp_stall_ext = ext; i_flush = fl; i_issue_vld = iv; i_issue_ent = ie;
    for (int i = 0; i < 8; i++) if (!m_busy[i]) fr.push_back(i);
    nreq    = int'(r1) + int'(r2);
    e.stall = nreq > m_free;
    commit  = !e.stall && !ext && !fl;
    e.v1 = r1 && commit;
    e.v2 = r2 && commit;
    e.e1 = (r1 && fr.size() > 0) ? 3'(fr[0]) : 3'd0;
    if (r1 && r2)                  e.e2 = (fr.size() > 1) ? 3'(fr[1]) : 3'd0;
    else if (r2 && fr.size() > 0)  e.e2 = 3'(fr[0]);
    else                           e.e2 = 3'd0;
    q.push_back(e);
    @(negedge i_clk);
    s_stall = o_rs_stall; s_v1 = o_alloc_vld_1; s_v2 = o_alloc_vld_2;
    s_e1 = o_alloc_ent_1; s_e2 = o_alloc_ent_2;
    if (q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = q.pop_front();
      chk("stall", 32'(s_stall), 32'(e.stall));
      chk("vld1",  32'(s_v1),    32'(e.v1));
      chk("ent1",  32'(s_e1),    32'(e.e1));
      chk("vld2",  32'(s_v2),    32'(e.v2));
      chk("ent2",  32'(s_e2),    32'(e.e2));
    end
    @(posedge i_clk);
    if (rst || fl) begin
      m_busy = 8'h00; m_free = 8;
    end else begin
      if (iv && m_busy[ie]) begin m_busy[ie] = 1'b0; m_free++; end
      if (e.v1) begin m_busy[e.e1] = 1'b1; m_free--; end
      if (e.v2) begin m_busy[e.e2] = 1'b1; m_free--; end
    end
    #1;
    chk("busy", 32'(o_busy_vec), 32'(m_busy));
    chk("free", 32'(o_free_cnt), 32'(m_free));
  endtask

  initial begin
    i_rst = 1'b1; i_rs_req_1 = 0; i_rs_req_2 = 0; i_rs_req_num = 0;
    i_dp_stall_ext = 0; i_flush = 0; i_issue_vld = 0; i_issue_ent = 0;
    m_busy = 8'h00; m_free = 8;
    @(posedge i_clk); #1;

    // Reset state, idle outputs
    cyc(0,0,0,0,0,0,0);
    chk("rst_busy", 32'(o_busy_vec), 32'h00);
    chk("rst_free", 32'(o_free_cnt), 32'd8);
    chk("rst_stall", 32'(s_stall), 32'd0);
    chk("rst_vld", 32'({s_v1, s_v2}), 32'd0);

    // Dual fill: (0,1),(2,3),(4,5),(6,7), then full stall
    for (int k = 0; k < 4; k++) begin
      cyc(0,1,1,0,0,0,0);
      chk("fill_e1", 32'(s_e1), 32'(2*k));
      chk("fill_e2", 32'(s_e2), 32'(2*k+1));
    end
    chk("full_busy", 32'(o_busy_vec), 32'hFF);
    chk("full_free", 32'(o_free_cnt), 32'd0);
    cyc(0,1,1,0,0,0,0);
    chk("full_stall", 32'(s_stall), 32'd1);
    chk("full_vld", 32'({s_v1, s_v2}), 32'd0);
    cyc(0,0,0,0,0,0,0);
    chk("full_nostall", 32'(s_stall), 32'd0);

    // One free entry: dual stalls, single slot-2 request takes entry 0
    cyc(0,0,0,0,0,1,3'd0);
    chk("fe_busy", 32'(o_busy_vec), 32'hFE);
    cyc(0,1,1,0,0,0,0);
    chk("fe_stall", 32'(s_stall), 32'd1);
    cyc(0,0,1,0,0,0,0);
    chk("fe_v2", 32'({s_v1, s_v2}), 32'b01);
    chk("fe_e2", 32'(s_e2), 32'd0);
    chk("fe_e1", 32'(s_e1), 32'd0);

    // Issue with no bypass, then reuse of entry 5
    cyc(0,1,0,0,0,1,3'd5);
    chk("nb_stall", 32'(s_stall), 32'd1);
    chk("nb_busy", 32'(o_busy_vec), 32'hDF);
    chk("nb_free", 32'(o_free_cnt), 32'd1);
    cyc(0,1,0,0,0,0,0);
    chk("nb_e1", 32'(s_e1), 32'd5);

    // busy 0F, dual alloc + issue 2
    cyc(1,0,0,0,0,0,0);
    cyc(0,1,1,0,0,0,0);
    cyc(0,1,1,0,0,0,0);
    cyc(0,1,1,0,0,1,3'd2);
    chk("ai_e1", 32'(s_e1), 32'd4);
    chk("ai_e2", 32'(s_e2), 32'd5);
    chk("ai_busy", 32'(o_busy_vec), 32'h3B);
    chk("ai_free", 32'(o_free_cnt), 32'd3);

    // busy 3C, flush with requests and issue
    cyc(1,0,0,0,0,0,0);
    for (int k = 0; k < 3; k++) cyc(0,1,1,0,0,0,0);
    cyc(0,0,0,0,0,1,3'd0);
    cyc(0,0,0,0,0,1,3'd1);
    chk("fl_pre", 32'(o_busy_vec), 32'h3C);
    cyc(0,1,1,0,1,1,3'd3);
    chk("fl_vld", 32'({s_v1, s_v2}), 32'd0);
    chk("fl_busy", 32'(o_busy_vec), 32'h00);
    chk("fl_free", 32'(o_free_cnt), 32'd8);

    // External stall, non-busy issue, mid-fill reset
    cyc(0,1,1,1,0,0,0);
    chk("ext_stall", 32'(s_stall), 32'd0);
    chk("ext_vld", 32'({s_v1, s_v2}), 32'd0);
    chk("ext_free", 32'(o_free_cnt), 32'd8);
    cyc(0,0,0,0,0,1,3'd7);
    chk("nbi_free", 32'(o_free_cnt), 32'd8);
    cyc(0,1,1,0,0,0,0);
    cyc(0,1,0,0,0,0,0);
    chk("mf_busy", 32'(o_busy_vec), 32'h07);
    cyc(1,1,1,0,0,1,3'd1);
    chk("mr_busy", 32'(o_busy_vec), 32'h00);
    chk("mr_free", 32'(o_free_cnt), 32'd8);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      cyc($urandom_range(0,63) == 0, 1'($urandom), 1'($urandom),
          $urandom_range(0,7) == 0, $urandom_range(0,23) == 0,
          1'($urandom), 3'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
